// File: rtl/ctu_clsp_pkg.sv
// -----------------------------------------------------------------------------
// ctu_clsp_pkg
// Shared definitions for the CTU CMP-domain clock/sync bring-up logic:
//   - seq_state_t : bring-up sequencer state encoding
//   - CKEN_*      : bit positions of the cluster clock enables in cmp_cken_cg
//   - MIN_RATIO   : smallest CMP:slow-clock ratio the sync generators honour
//   - eff_ratio() : clamps a programmed ratio to MIN_RATIO
// -----------------------------------------------------------------------------
package ctu_clsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_CKEN      = 3'd2,
        ST_GRST_WAIT = 3'd3,
        ST_RUN       = 3'd4,
        ST_WRST      = 3'd5,
        ST_DBG       = 3'd6
    } seq_state_t;

    localparam int CKEN_CCX     = 0;
    localparam int CKEN_DRAM02  = 1;
    localparam int CKEN_DRAM13  = 2;
    localparam int CKEN_FPU     = 3;
    localparam int CKEN_IOB     = 4;
    localparam int CKEN_JBI     = 5;
    localparam int CKEN_SCDATA0 = 6;
    localparam int CKEN_SCDATA1 = 7;
    localparam int CKEN_SCDATA2 = 8;
    localparam int CKEN_SCDATA3 = 9;
    localparam int CKEN_SCTAG0  = 10;
    localparam int CKEN_SCTAG1  = 11;
    localparam int CKEN_SCTAG2  = 12;
    localparam int CKEN_SCTAG3  = 13;
    localparam int CKEN_SPARC0  = 14;
    localparam int CKEN_SPARC1  = 15;
    localparam int CKEN_SPARC2  = 16;
    localparam int CKEN_SPARC3  = 17;
    localparam int CKEN_SPARC4  = 18;
    localparam int CKEN_SPARC5  = 19;
    localparam int CKEN_SPARC6  = 20;
    localparam int CKEN_SPARC7  = 21;

    localparam logic [3:0] MIN_RATIO = 4'd2;

    // Ratios of 0 or 1 cannot give distinct rx/tx cycles, so they run as 2.
    function automatic logic [3:0] eff_ratio(input logic [3:0] ratio);
        logic [3:0] r;
        if (ratio < MIN_RATIO) begin
            r = MIN_RATIO;
        end else begin
            r = ratio;
        end
        return r;
    endfunction

endpackage

// File: rtl/ctu_clsp_syncgen.sv
// -----------------------------------------------------------------------------
// ctu_clsp_syncgen
// Slow-clock sync pulse generator. A 4-bit down-counter walks r-1 .. 0 across
// one slow period; rx_sync marks the first CMP cycle of the period and
// tx_sync the last. The ratio is re-sampled only when the counter reloads.
// Ports:
//   clk      in   CMP clock
//   rst      in   synchronous active-high reset
//   en       in   run enable (start-clock qualifier)
//   ratio    in   CMP cycles per slow cycle (values below 2 run as 2)
//   rx_sync  out  registered first-cycle pulse
//   tx_sync  out  registered last-cycle pulse
// -----------------------------------------------------------------------------
module ctu_clsp_syncgen (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] ratio,
    output logic       rx_sync,
    output logic       tx_sync
);
    import ctu_clsp_pkg::*;

    logic [3:0] cnt_r;
    logic [3:0] per_r;
    logic [3:0] cnt_nxt_s;
    logic [3:0] per_nxt_s;
    logic       rx_nxt_s;
    logic       tx_nxt_s;

    // Next counter/period and pulse decode.
    always_comb begin
        cnt_nxt_s = cnt_r;
        per_nxt_s = per_r;
        rx_nxt_s  = 1'b0;
        tx_nxt_s  = 1'b0;
        if (!en) begin
            // Keep the counter preloaded so the first enabled cycle is an rx.
            per_nxt_s = eff_ratio(ratio);
            cnt_nxt_s = eff_ratio(ratio) - 4'd1;
        end else begin
            rx_nxt_s = (cnt_r == (per_r - 4'd1));
            tx_nxt_s = (cnt_r == 4'd0);
            if (cnt_r == 4'd0) begin
                per_nxt_s = eff_ratio(ratio);
                cnt_nxt_s = eff_ratio(ratio) - 4'd1;
            end else begin
                cnt_nxt_s = cnt_r - 4'd1;
            end
        end
    end

    // Counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 4'd1;
            per_r   <= MIN_RATIO;
            rx_sync <= 1'b0;
            tx_sync <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            per_r   <= per_nxt_s;
            rx_sync <= rx_nxt_s;
            tx_sync <= tx_nxt_s;
        end
    end

endmodule

// File: rtl/ctu_clsp_cmpseq.sv
// -----------------------------------------------------------------------------
// ctu_clsp_cmpseq
// CMP-domain bring-up sequencer. On start_req it raises the start-clock
// qualifier, staggers the cluster clock enables on one slot per STAGGER
// cycles, releases global reset / debug-init GRST_DLY cycles after the last
// slot, then services warm-reset and debug-init pulse requests. Two sync
// generators produce the DRAM and JBUS rx/tx sync pulses.
// Ports:
//   cmp_gclk, cmp_rst               clock, synchronous active-high reset
//   start_req                       begin bring-up (IDLE only)
//   warm_rst_req, dbginit_req       pulse requests (RUN only, warm wins)
//   cken_mask[NUM_CKEN]             CSR cluster enable mask
//   dram_ratio, jbus_ratio          CMP:slow-clock ratios
//   start_clk_cl                    start-clock qualifier
//   cmp_grst_cl_l, cmp_dbginit_cl_l global reset / debug-init, active low
//   cmp_cken_cg[NUM_CKEN]           cluster clock enables
//   ctu_{dram,jbus}_{tx,rx}_sync_cl sync pulses
//   seq_busy, seq_done              sequencer status
// All outputs are registered.
// -----------------------------------------------------------------------------
module ctu_clsp_cmpseq #(
    parameter int NUM_CKEN = 22,
    parameter int STAGGER  = 4,
    parameter int GRST_DLY = 16
) (
    input  logic                cmp_gclk,
    input  logic                cmp_rst,
    input  logic                start_req,
    input  logic                warm_rst_req,
    input  logic                dbginit_req,
    input  logic [NUM_CKEN-1:0] cken_mask,
    input  logic [3:0]          dram_ratio,
    input  logic [3:0]          jbus_ratio,
    output logic                start_clk_cl,
    output logic                cmp_grst_cl_l,
    output logic                cmp_dbginit_cl_l,
    output logic [NUM_CKEN-1:0] cmp_cken_cg,
    output logic                ctu_dram_tx_sync_cl,
    output logic                ctu_dram_rx_sync_cl,
    output logic                ctu_jbus_tx_sync_cl,
    output logic                ctu_jbus_rx_sync_cl,
    output logic                seq_busy,
    output logic                seq_done
);
    import ctu_clsp_pkg::*;

    localparam int MAX_DLY = (STAGGER > GRST_DLY) ? STAGGER : GRST_DLY;
    localparam int CNT_W   = $clog2(MAX_DLY + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] GRST_LAST = CNT_W'(GRST_DLY - 1);
    localparam logic [CNT_W-1:0] GRST_END  = CNT_W'(GRST_DLY);
    // Slot index one past the last enable marks the end of the stagger.
    localparam logic [4:0]       SLOT_END  = 5'(NUM_CKEN);

    seq_state_t          state_r, state_nxt_s;
    logic [4:0]          slot_r, slot_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                start_clk_r, start_clk_nxt_s;
    logic                grst_l_r, grst_l_nxt_s;
    logic                dbg_l_r, dbg_l_nxt_s;
    logic [NUM_CKEN-1:0] cken_r, cken_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;

    // Next-state and next-output logic of the bring-up sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        slot_nxt_s      = slot_r;
        cnt_nxt_s       = cnt_r;
        start_clk_nxt_s = start_clk_r;
        grst_l_nxt_s    = grst_l_r;
        dbg_l_nxt_s     = dbg_l_r;
        cken_nxt_s      = cken_r;
        case (state_r)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                start_clk_nxt_s = 1'b1;
                slot_nxt_s      = 5'd0;
                cnt_nxt_s       = CNT_ZERO;
                state_nxt_s     = ST_CKEN;
            end
            ST_CKEN: begin
                if (slot_r == SLOT_END) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_GRST_WAIT;
                end else begin
                    // The enable is written on the first cycle of its slot;
                    // masked bits are written as 0 but still use the slot.
                    for (int i = 0; i < NUM_CKEN; i++) begin
                        cken_nxt_s[i] = ((cnt_r == CNT_ZERO) && (slot_r == 5'(i)))
                                        ? cken_mask[i] : cken_r[i];
                    end
                    if (cnt_r == STAG_LAST) begin
                        cnt_nxt_s  = CNT_ZERO;
                        slot_nxt_s = slot_r + 5'd1;
                    end else begin
                        cnt_nxt_s  = cnt_r + CNT_ONE;
                    end
                end
            end
            ST_GRST_WAIT: begin
                if (cnt_r == GRST_LAST) begin
                    grst_l_nxt_s = 1'b1;
                    dbg_l_nxt_s  = 1'b1;
                    cnt_nxt_s    = CNT_ZERO;
                    state_nxt_s  = ST_RUN;
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                cken_nxt_s = cken_mask;
                cnt_nxt_s  = CNT_ZERO;
                if (warm_rst_req) begin
                    state_nxt_s = ST_WRST;
                end else if (dbginit_req) begin
                    state_nxt_s = ST_DBG;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WRST: begin
                // Lines go low one cycle after the request and stay low for
                // GRST_DLY cycles; the extra count value is the release edge.
                if (cnt_r == GRST_END) begin
                    grst_l_nxt_s = 1'b1;
                    dbg_l_nxt_s  = 1'b1;
                    state_nxt_s  = ST_RUN;
                end else begin
                    grst_l_nxt_s = 1'b0;
                    dbg_l_nxt_s  = 1'b0;
                    cnt_nxt_s    = cnt_r + CNT_ONE;
                end
            end
            ST_DBG: begin
                if (cnt_r == GRST_END) begin
                    dbg_l_nxt_s = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    dbg_l_nxt_s = 1'b0;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_START) || (state_nxt_s == ST_CKEN) ||
                     (state_nxt_s == ST_GRST_WAIT) || (state_nxt_s == ST_WRST) ||
                     (state_nxt_s == ST_DBG);
        done_nxt_s = (state_nxt_s == ST_RUN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge cmp_gclk) begin
        if (cmp_rst) begin
            state_r     <= ST_IDLE;
            slot_r      <= 5'd0;
            cnt_r       <= CNT_ZERO;
            start_clk_r <= 1'b0;
            grst_l_r    <= 1'b0;
            dbg_l_r     <= 1'b0;
            cken_r      <= {NUM_CKEN{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            slot_r      <= slot_nxt_s;
            cnt_r       <= cnt_nxt_s;
            start_clk_r <= start_clk_nxt_s;
            grst_l_r    <= grst_l_nxt_s;
            dbg_l_r     <= dbg_l_nxt_s;
            cken_r      <= cken_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign start_clk_cl     = start_clk_r;
    assign cmp_grst_cl_l    = grst_l_r;
    assign cmp_dbginit_cl_l = dbg_l_r;
    assign cmp_cken_cg      = cken_r;
    assign seq_busy         = busy_r;
    assign seq_done         = done_r;

    ctu_clsp_syncgen u_dram_sync (
        .clk     (cmp_gclk),
        .rst     (cmp_rst),
        .en      (start_clk_r),
        .ratio   (dram_ratio),
        .rx_sync (ctu_dram_rx_sync_cl),
        .tx_sync (ctu_dram_tx_sync_cl)
    );

    ctu_clsp_syncgen u_jbus_sync (
        .clk     (cmp_gclk),
        .rst     (cmp_rst),
        .en      (start_clk_r),
        .ratio   (jbus_ratio),
        .rx_sync (ctu_jbus_rx_sync_cl),
        .tx_sync (ctu_jbus_tx_sync_cl)
    );

endmodule

// File: tb/tb_ctu_clsp_cmpseq.sv
// -----------------------------------------------------------------------------
// tb_ctu_clsp_cmpseq
// Timeline reference model: each clock edge the model turns the sampled
// inputs into the expected outputs after that edge (computed from start time,
// release time, request windows and slow-clock periods) and queues them; a
// monitor pops one entry per cycle on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_ctu_clsp_cmpseq;
    localparam int N = 22;
    localparam int S = 4;
    localparam int G = 16;

    logic          cmp_gclk;
    logic          cmp_rst;
    logic          start_req;
    logic          warm_rst_req;
    logic          dbginit_req;
    logic [N-1:0]  cken_mask;
    logic [3:0]    dram_ratio;
    logic [3:0]    jbus_ratio;
    logic          start_clk_cl;
    logic          cmp_grst_cl_l;
    logic          cmp_dbginit_cl_l;
    logic [N-1:0]  cmp_cken_cg;
    logic          ctu_dram_tx_sync_cl;
    logic          ctu_dram_rx_sync_cl;
    logic          ctu_jbus_tx_sync_cl;
    logic          ctu_jbus_rx_sync_cl;
    logic          seq_busy;
    logic          seq_done;

    ctu_clsp_cmpseq #(.NUM_CKEN(N), .STAGGER(S), .GRST_DLY(G)) dut (
        .cmp_gclk            (cmp_gclk),
        .cmp_rst             (cmp_rst),
        .start_req           (start_req),
        .warm_rst_req        (warm_rst_req),
        .dbginit_req         (dbginit_req),
        .cken_mask           (cken_mask),
        .dram_ratio          (dram_ratio),
        .jbus_ratio          (jbus_ratio),
        .start_clk_cl        (start_clk_cl),
        .cmp_grst_cl_l       (cmp_grst_cl_l),
        .cmp_dbginit_cl_l    (cmp_dbginit_cl_l),
        .cmp_cken_cg         (cmp_cken_cg),
        .ctu_dram_tx_sync_cl (ctu_dram_tx_sync_cl),
        .ctu_dram_rx_sync_cl (ctu_dram_rx_sync_cl),
        .ctu_jbus_tx_sync_cl (ctu_jbus_tx_sync_cl),
        .ctu_jbus_rx_sync_cl (ctu_jbus_rx_sync_cl),
        .seq_busy            (seq_busy),
        .seq_done            (seq_done)
    );

    typedef struct packed {
        logic [4:0]   ctrl;   // start_clk, grst_l, dbginit_l, busy, done
        logic [N-1:0] cken;
        logic [3:0]   sync;   // dram rx, dram tx, jbus rx, jbus tx
    } exp_t;

    exp_t exp_q[$];
    int   errors;
    int   checks;

    initial begin
        cmp_gclk = 1'b0;
        forever #5 cmp_gclk = ~cmp_gclk;
    end

    function automatic int eff(input logic [3:0] r);
        if (r < 4'd2) return 2;
        else return int'(r);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, req);
        end
    endtask

    // One slow-clock domain: rx on the period's first cycle, tx on its last,
    // the next period length taken from the ratio seen on the tx cycle.
    task automatic sync_step(input int n, input int ts, input logic [3:0] ratio,
                             inout int nxt, inout int per, output bit rx, output bit tx);
        rx = 1'b0;
        tx = 1'b0;
        if (ts >= 0 && n == ts + 1) begin
            per = eff(ratio);
            nxt = n + 1;
        end else if (ts >= 0 && n >= ts + 2) begin
            rx = (n == nxt);
            tx = (n == nxt + per - 1);
            if (tx) begin
                per = eff(ratio);
                nxt = n + 1;
            end
        end
    endtask

    // Reference model, evaluated at every rising edge.
    initial begin
        int n, t_start, t_rel, pr, busy_until, d_next, d_per, j_next, j_per;
        bit pw, done_prev, started, rel, inp, low, done, drx, dtx, jrx, jtx;
        logic [N-1:0] ck;
        exp_t e;
        n = 0; t_start = -1; t_rel = 0; pr = -1000; busy_until = 0;
        d_next = 0; d_per = 2; j_next = 0; j_per = 2;
        pw = 1'b0; done_prev = 1'b0; ck = '0;
        forever begin
            @(posedge cmp_gclk);
            if (cmp_rst) begin
                t_start = -1; pr = -1000; ck = '0; done_prev = 1'b0;
            end else begin
                if (t_start < 0) begin
                    if (start_req) begin
                        t_start    = n;
                        t_rel      = n + 2 + N * S + G;
                        busy_until = t_rel;
                    end
                end else if (n > busy_until) begin
                    if (warm_rst_req) begin
                        pr = n; pw = 1'b1; busy_until = n + 1 + G;
                    end else if (dbginit_req) begin
                        pr = n; pw = 1'b0; busy_until = n + 1 + G;
                    end
                end
                if (done_prev) begin
                    ck = cken_mask;
                end else if (t_start >= 0) begin
                    for (int i = 0; i < N; i++)
                        if (n == t_start + 2 + i * S) ck[i] = cken_mask[i];
                end
            end
            sync_step(n, t_start, dram_ratio, d_next, d_per, drx, dtx);
            sync_step(n, t_start, jbus_ratio, j_next, j_per, jrx, jtx);
            started = (t_start >= 0);
            rel  = started && (n >= t_rel);
            inp  = (n >= pr) && (n <= pr + G);
            low  = (n >= pr + 1) && (n <= pr + G);
            done = rel && !inp;
            e.ctrl = {started && (n >= t_start + 1), rel && !(low && pw), rel && !low,
                      started && !done, done};
            e.cken = ck;
            e.sync = {drx, dtx, jrx, jtx};
            exp_q.push_back(e);
            done_prev = done;
            n++;
        end
    end

    // Monitor: one expected entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        errors = 0;
        checks = 0;
        forever begin
            @(negedge cmp_gclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ctrl", 32'({start_clk_cl, cmp_grst_cl_l, cmp_dbginit_cl_l, seq_busy, seq_done}), 32'(e.ctrl));
                check("cken", 32'(cmp_cken_cg), 32'(e.cken));
                check("sync", 32'({ctu_dram_rx_sync_cl, ctu_dram_tx_sync_cl,
                                   ctu_jbus_rx_sync_cl, ctu_jbus_tx_sync_cl}), 32'(e.sync));
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge cmp_gclk);
    endtask

    task automatic pulse(input int which);
        @(negedge cmp_gclk);
        start_req    = (which == 0);
        warm_rst_req = (which == 1) || (which == 3);
        dbginit_req  = (which == 2) || (which == 3);
        @(negedge cmp_gclk);
        start_req = 1'b0; warm_rst_req = 1'b0; dbginit_req = 1'b0;
    endtask

    // Stimulus.
    initial begin
        cmp_rst = 1'b1; start_req = 1'b0; warm_rst_req = 1'b0; dbginit_req = 1'b0;
        cken_mask = {N{1'b1}}; dram_ratio = 4'd4; jbus_ratio = 4'd3;
        cycles(3);
        cmp_rst = 1'b0;
        cycles(6);
        pulse(0);                       // full bring-up, all-ones mask
        cycles(120);
        dram_ratio = 4'd6;  cycles(9);  // mid-period ratio changes
        jbus_ratio = 4'd0;  cycles(12);
        dram_ratio = 4'd1;  cycles(12);
        pulse(1); cycles(6);            // warm reset, then a dbginit inside it
        pulse(2); cycles(25);
        pulse(3); cycles(25);           // simultaneous: warm wins
        pulse(2); cycles(25);           // dbginit alone
        for (int k = 0; k < 4; k++) begin
            cken_mask = N'($urandom); cycles(2);
        end
        pulse(0); cycles(5);            // start in RUN is ignored
        cmp_rst = 1'b1; cycles(1); cmp_rst = 1'b0; cycles(2);
        pulse(0); cycles(29);
        cmp_rst = 1'b1; cycles(1); cmp_rst = 1'b0; cycles(2);   // reset in slot 7
        cken_mask = 22'h2AAAAA; dram_ratio = 4'd4; jbus_ratio = 4'd3;
        pulse(0); cycles(120);          // masked bring-up
        for (int k = 0; k < 1500; k++) begin
            @(negedge cmp_gclk);
            start_req    = ($urandom_range(0, 99) == 0);
            warm_rst_req = ($urandom_range(0, 39) == 0);
            dbginit_req  = ($urandom_range(0, 39) == 0);
            cmp_rst      = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 15) == 0) dram_ratio = 4'($urandom);
            if ($urandom_range(0, 15) == 0) jbus_ratio = 4'($urandom);
            if ($urandom_range(0, 63) == 0) cken_mask = N'($urandom);
        end
        @(negedge cmp_gclk);
        start_req = 1'b0; warm_rst_req = 1'b0; dbginit_req = 1'b0; cmp_rst = 1'b0;
        cycles(4);
        #1;
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL drain entries=%0d expected<=1", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
